// File: rtl/rt_loader_pkg.sv
// Shared types and constants for the racetrack/LiM boot preload sequencer.
package rt_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_FETCH,
    LD_ISSUE,
    LD_WAIT_ACK,
    LD_GAP,
    LD_DRAIN,
    LD_DONE,
    LD_ERROR
  } rt_ld_state_e;

  localparam int RT_DRAIN_CYCLES = 3;
  localparam int RT_GAP_CYCLES   = 1;

  localparam logic [3:0] RT_FULL_BE = 4'hF;

endpackage

// File: rtl/rt_portb_mux.sv
// Port-B ownership mux: the loader drives memory port B until the preload is
// done, after which the core-side requester is passed straight through.
module rt_portb_mux #(
  parameter int ADDR_WIDTH  = 22,
  parameter int FUNCT_WIDTH = 4
) (
  input  logic                   sel_core,
  input  logic                   ld_en,
  input  logic                   ld_we,
  input  logic [3:0]             ld_be,
  input  logic [ADDR_WIDTH-1:0]  ld_addr,
  input  logic [31:0]            ld_wdata,
  input  logic                   core_en,
  input  logic                   core_we,
  input  logic [3:0]             core_be,
  input  logic [ADDR_WIDTH-1:0]  core_addr,
  input  logic [31:0]            core_wdata,
  input  logic [FUNCT_WIDTH-1:0] core_funct,
  input  logic                   core_we_funct,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [3:0]             mem_be,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [FUNCT_WIDTH-1:0] mem_funct,
  output logic                   mem_we_funct
);

  assign mem_en    = sel_core ? core_en    : ld_en;
  assign mem_we    = sel_core ? core_we    : ld_we;
  assign mem_be    = sel_core ? core_be    : ld_be;
  assign mem_addr  = sel_core ? core_addr  : ld_addr;
  assign mem_wdata = sel_core ? core_wdata : ld_wdata;

  // The loader only ever issues plain word writes, so LiM fields stay quiet.
  assign mem_funct    = sel_core ? core_funct : '0;
  assign mem_we_funct = sel_core ? core_we_funct : 1'b0;

endmodule

// File: rtl/rt_boot_loader.sv
// Boot preload sequencer: copies NUM_WORDS words from the boot source into
// memory port B, then hands the port to the core and enables instruction fetch.
module rt_boot_loader
  import rt_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 22,
  parameter int NUM_WORDS   = 4088,
  parameter int START_ADDR  = 0,
  parameter int FUNCT_WIDTH = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  output logic                             src_req_o,
  output logic [$clog2(NUM_WORDS)-1:0]     src_idx_o,
  input  logic                             src_valid_i,
  input  logic [31:0]                      src_data_i,
  input  logic                             core_en_i,
  input  logic                             core_we_i,
  input  logic [3:0]                       core_be_i,
  input  logic [ADDR_WIDTH-1:0]            core_addr_i,
  input  logic [31:0]                      core_wdata_i,
  input  logic [FUNCT_WIDTH-1:0]           core_funct_i,
  input  logic                             core_we_funct_i,
  output logic                             mem_en_o,
  output logic                             mem_we_o,
  output logic [3:0]                       mem_be_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [31:0]                      mem_wdata_o,
  output logic [FUNCT_WIDTH-1:0]           mem_funct_o,
  output logic                             mem_we_funct_o,
  input  logic                             mem_rvalid_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             error_o,
  output logic                             fetch_enable_o,
  output logic [$clog2(NUM_WORDS+1)-1:0]   word_cnt_o
);

  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int CNT_W  = $clog2(NUM_WORDS + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  rt_ld_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        phase_q, phase_d;

  logic                  src_req;
  logic                  ld_en;
  logic                  ld_hold;
  logic [ADDR_WIDTH-1:0] ld_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      phase_q <= phase_d;
    end
  end

  // phase_q is shared by GAP and DRAIN; it is always zero on entry to either.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    phase_d = phase_q;
    src_req = 1'b0;
    ld_en   = 1'b0;
    ld_hold = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = LD_FETCH;
        end
      end
      LD_FETCH: begin
        src_req = 1'b1;
        if (src_valid_i) begin
          data_d  = src_data_i;
          state_d = LD_ISSUE;
        end
      end
      LD_ISSUE: begin
        ld_en   = 1'b1;
        ld_hold = 1'b1;
        wait_d  = '0;
        state_d = LD_WAIT_ACK;
      end
      LD_WAIT_ACK: begin
        ld_hold = 1'b1;
        // A completion on the final allowed cycle still commits the word.
        if (mem_rvalid_i) begin
          cnt_d   = cnt_q + CNT_W'(1);
          phase_d = '0;
          state_d = LD_GAP;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = LD_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      LD_GAP: begin
        if (phase_q == 2'(RT_GAP_CYCLES - 1)) begin
          phase_d = '0;
          if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
            state_d = LD_DRAIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LD_FETCH;
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      LD_DRAIN: begin
        if (phase_q == 2'(RT_DRAIN_CYCLES - 1)) begin
          state_d = LD_DONE;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      LD_DONE, LD_ERROR: begin
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // Word address wraps modulo 2^ADDR_WIDTH by plain truncation.
  assign ld_addr = ld_hold ? (ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'({idx_q, 2'b00})) : '0;

  rt_portb_mux #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_portb_mux (
    .sel_core      (state_q == LD_DONE),
    .ld_en         (ld_en),
    .ld_we         (ld_hold),
    .ld_be         (ld_hold ? RT_FULL_BE : 4'h0),
    .ld_addr       (ld_addr),
    .ld_wdata      (ld_hold ? data_q : 32'h0),
    .core_en       (core_en_i),
    .core_we       (core_we_i),
    .core_be       (core_be_i),
    .core_addr     (core_addr_i),
    .core_wdata    (core_wdata_i),
    .core_funct    (core_funct_i),
    .core_we_funct (core_we_funct_i),
    .mem_en        (mem_en_o),
    .mem_we        (mem_we_o),
    .mem_be        (mem_be_o),
    .mem_addr      (mem_addr_o),
    .mem_wdata     (mem_wdata_o),
    .mem_funct     (mem_funct_o),
    .mem_we_funct  (mem_we_funct_o)
  );

  assign src_req_o      = src_req;
  assign src_idx_o      = idx_q;
  assign word_cnt_o     = cnt_q;
  assign busy_o         = state_q inside {LD_FETCH, LD_ISSUE, LD_WAIT_ACK, LD_GAP, LD_DRAIN};
  assign done_o         = (state_q == LD_DONE);
  assign fetch_enable_o = (state_q == LD_DONE);
  assign error_o        = (state_q == LD_ERROR);

endmodule

// File: tb/tb_rt_boot_loader.sv
// Randomized bench for rt_boot_loader: a cycle schedule built from chosen
// source/memory latencies predicts every port-B write and status output.
module tb_rt_boot_loader;

  localparam int TO = 8;
  localparam int NW = 4;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        src_valid;
  logic [31:0] src_data;
  logic        core_en, core_we, core_we_funct;
  logic [3:0]  core_be, core_funct;
  logic [21:0] core_addr;
  logic [31:0] core_wdata;
  logic        mem_rvalid;

  logic        a_src_req, a_mem_en, a_mem_we, a_mem_we_funct;
  logic [1:0]  a_src_idx;
  logic [3:0]  a_mem_be, a_mem_funct;
  logic [21:0] a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic        a_busy, a_done, a_error, a_fe;
  logic [2:0]  a_cnt;

  logic        b_src_req, b_mem_en, b_mem_we, b_mem_we_funct;
  logic [0:0]  b_src_idx;
  logic [3:0]  b_mem_be, b_mem_funct;
  logic [21:0] b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic        b_busy, b_done, b_error, b_fe;
  logic [1:0]  b_cnt;

  rt_boot_loader #(.ADDR_WIDTH(22), .NUM_WORDS(NW), .START_ADDR(0), .FUNCT_WIDTH(4), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .src_req_o(a_src_req), .src_idx_o(a_src_idx), .src_valid_i(src_valid), .src_data_i(src_data),
    .core_en_i(core_en), .core_we_i(core_we), .core_be_i(core_be), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_funct_i(core_funct), .core_we_funct_i(core_we_funct),
    .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_funct_o(a_mem_funct), .mem_we_funct_o(a_mem_we_funct),
    .mem_rvalid_i(mem_rvalid), .busy_o(a_busy), .done_o(a_done), .error_o(a_error),
    .fetch_enable_o(a_fe), .word_cnt_o(a_cnt)
  );

  // Second instance shares all inputs; it exercises address wrap at the top of memory.
  rt_boot_loader #(.ADDR_WIDTH(22), .NUM_WORDS(2), .START_ADDR(32'h3FFFFC), .FUNCT_WIDTH(4), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .src_req_o(b_src_req), .src_idx_o(b_src_idx), .src_valid_i(src_valid), .src_data_i(src_data),
    .core_en_i(core_en), .core_we_i(core_we), .core_be_i(core_be), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_funct_i(core_funct), .core_we_funct_i(core_we_funct),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_funct_o(b_mem_funct), .mem_we_funct_o(b_mem_we_funct),
    .mem_rvalid_i(mem_rvalid), .busy_o(b_busy), .done_o(b_done), .error_o(b_error),
    .fetch_enable_o(b_fe), .word_cnt_o(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt;
  int err_cnt;
  int cyc;

  int          sl[NW];
  int          ml[NW];
  logic [31:0] src_mem[NW];
  int          fetch_c[NW], issue_c[NW], ack_c[NW], gap_c[NW];
  int          done_c, err_c, n_sched;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [21:0] expAddr(input int unsigned start, input int i);
    int unsigned a;
    a = start + 32'(4 * i);
    return a[21:0];
  endfunction

  task automatic randomizeRun();
    for (int i = 0; i < NW; i++) begin
      sl[i]      = $urandom_range(1, 4);
      ml[i]      = $urandom_range(1, TO);
      src_mem[i] = $urandom;
    end
  endtask

  // Cycle 1 is the first cycle after start_i is sampled; each word takes
  // src latency + 1 issue + mem latency + 1 gap, then 3 drain cycles.
  task automatic buildSchedule(input int timeout_word);
    int base;
    base = 1; done_c = -1; err_c = -1; n_sched = NW;
    for (int i = 0; i < NW; i++) begin
      fetch_c[i] = base;
      issue_c[i] = base + sl[i];
      if (i == timeout_word) begin
        ack_c[i] = -1;
        gap_c[i] = -1;
        err_c    = issue_c[i] + 1 + TO;
        n_sched  = i + 1;
        break;
      end
      ack_c[i] = issue_c[i] + ml[i];
      gap_c[i] = ack_c[i] + 1;
      base     = gap_c[i] + 1;
    end
    if (err_c < 0) done_c = base + 3;
  endtask

  task automatic applyStimulus(input int timeout_word, input bit spurious, input int abort_word, input bit check_b);
    int last, abort_cyc, hold_end, exp_idx, exp_cnt;
    bit exp_req, exp_en, exp_we, in_done, in_err;
    logic [21:0] exp_addr;
    logic [31:0] exp_data;
    buildSchedule(timeout_word);
    abort_cyc = (abort_word >= 0) ? issue_c[abort_word] + 1 : -1;
    last = ((err_c >= 0) ? err_c : done_c) + 4;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      cyc = c;
      exp_req = 0; exp_idx = 0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_data = '0; exp_cnt = 0;
      for (int i = 0; i < n_sched; i++) begin
        hold_end = (ack_c[i] >= 0) ? ack_c[i] : err_c - 1;
        if (c >= fetch_c[i] && c < issue_c[i]) begin exp_req = 1; exp_idx = i; end
        if (c == issue_c[i]) exp_en = 1;
        if (c >= issue_c[i] && c <= hold_end) begin
          exp_we = 1; exp_addr = expAddr(0, i); exp_data = src_mem[i];
        end
        if (ack_c[i] >= 0 && ack_c[i] < c) exp_cnt++;
      end
      in_done = (done_c >= 0 && c >= done_c);
      in_err  = (err_c >= 0 && c >= err_c);
      checkOutput("busy", a_busy, c >= 1 && !in_done && !in_err);
      checkOutput("fetch_en", a_fe, in_done);
      checkOutput("done", a_done, in_done);
      checkOutput("error", a_error, in_err);
      checkOutput("word_cnt", a_cnt, exp_cnt);
      checkOutput("src_req", a_src_req, exp_req);
      if (exp_req) checkOutput("src_idx", a_src_idx, exp_idx);
      if (!in_done) begin
        checkOutput("mem_en", a_mem_en, exp_en);
        checkOutput("mem_funct", a_mem_funct, 0);
        checkOutput("mem_we_funct", a_mem_we_funct, 0);
        if (exp_we) begin
          checkOutput("mem_we", a_mem_we, 1);
          checkOutput("mem_be", a_mem_be, 4'hF);
          checkOutput("mem_addr", a_mem_addr, exp_addr);
          checkOutput("mem_wdata", a_mem_wdata, exp_data);
        end
      end
      if (check_b) begin
        for (int i = 0; i < 2; i++) begin
          if (c == issue_c[i]) begin
            checkOutput("b_mem_en", b_mem_en, 1);
            checkOutput("b_mem_addr", b_mem_addr, expAddr(32'h3FFFFC, i));
            checkOutput("b_mem_wdata", b_mem_wdata, src_mem[i]);
          end
        end
        if (c == gap_c[1] + 3) checkOutput("b_fetch_en_early", b_fe, 0);
        if (c == gap_c[1] + 4) checkOutput("b_fetch_en", b_fe, 1);
      end
      if (c == abort_cyc) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_mem_en", a_mem_en, 0);
        checkOutput("rst_mem_we", a_mem_we, 0);
        checkOutput("rst_mem_addr", a_mem_addr, 0);
        checkOutput("rst_word_cnt", a_cnt, 0);
        checkOutput("rst_fetch_en", a_fe, 0);
        return;
      end
      start_i    = (c == 0) || (c > 1 && $urandom_range(0, 3) == 0);
      src_valid  = 1'b0;
      src_data   = $urandom;
      mem_rvalid = 1'b0;
      for (int i = 0; i < n_sched; i++) begin
        if (c == issue_c[i] - 1) begin src_valid = 1'b1; src_data = src_mem[i]; end
        if (c == ack_c[i]) mem_rvalid = 1'b1;
        if (spurious && (c == issue_c[i] || c == gap_c[i])) mem_rvalid = 1'b1;
      end
      core_en       = 1'b1;
      core_funct    = 4'h5;
      core_we       = 1'($urandom);
      core_we_funct = 1'($urandom);
      core_be       = 4'($urandom);
      core_addr     = 22'($urandom);
      core_wdata    = $urandom;
    end
  endtask

  task automatic checkPassthrough();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cyc = -1;
      core_en = 1'($urandom); core_we = 1'($urandom); core_we_funct = 1'($urandom);
      core_be = 4'($urandom); core_funct = 4'($urandom);
      core_addr = 22'($urandom); core_wdata = $urandom;
      #1;
      checkOutput("pt_en", a_mem_en, core_en);
      checkOutput("pt_we", a_mem_we, core_we);
      checkOutput("pt_be", a_mem_be, core_be);
      checkOutput("pt_addr", a_mem_addr, core_addr);
      checkOutput("pt_wdata", a_mem_wdata, core_wdata);
      checkOutput("pt_funct", a_mem_funct, core_funct);
      checkOutput("pt_we_funct", a_mem_we_funct, core_we_funct);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0; src_valid = 1'b0; mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    cyc = -2;
    checkOutput("reset_fetch_en", a_fe, 0);
    checkOutput("reset_word_cnt", a_cnt, 0);
    checkOutput("reset_mem_en", a_mem_en, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0; cyc = -2;
    rst_n = 1'b0; start_i = 1'b0; src_valid = 1'b0; src_data = '0; mem_rvalid = 1'b0;
    core_en = 1'b1; core_we = 1'b1; core_we_funct = 1'b1; core_be = 4'hF;
    core_funct = 4'h5; core_addr = '1; core_wdata = '1;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", a_busy, 0);
    checkOutput("reset_done", a_done, 0);
    checkOutput("reset_error", a_error, 0);
    checkOutput("reset_fetch_en", a_fe, 0);
    checkOutput("reset_mem_en", a_mem_en, 0);
    checkOutput("reset_mem_funct", a_mem_funct, 0);
    checkOutput("reset_src_req", a_src_req, 0);
    checkOutput("reset_b_mem_en", b_mem_en, 0);
    rst_n = 1'b1;

    $display("[TB] run: fixed latencies src=1 mem=3");
    for (int i = 0; i < NW; i++) begin sl[i] = 1; ml[i] = 3; src_mem[i] = $urandom; end
    applyStimulus(-1, 1'b0, -1, 1'b1);
    cyc = -1;
    checkOutput("final_word_cnt", a_cnt, NW);
    checkPassthrough();

    $display("[TB] run: random latencies, ack on timeout cycle, spurious rvalid");
    doReset(); randomizeRun(); ml[2] = TO;
    applyStimulus(-1, 1'b1, -1, 1'b1);

    $display("[TB] run: reset during WAIT_ACK of word 2, then restart");
    doReset(); randomizeRun(); ml[1] = 3;
    applyStimulus(-1, 1'b0, 1, 1'b0);
    doReset(); randomizeRun();
    applyStimulus(-1, 1'b0, -1, 1'b1);

    $display("[TB] run: memory never acknowledges word 1");
    doReset(); randomizeRun();
    applyStimulus(1, 1'b0, -1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      $display("[TB] run: random %0d", r);
      doReset(); randomizeRun();
      applyStimulus(-1, 1'($urandom), -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rt_boot_loader.md
# rt_boot_loader

Hardware preload sequencer for the racetrack/LiM data memory. After reset it copies `NUM_WORDS` 32-bit words from a boot-source read port into memory port B with plain word writes, with LiM operations suppressed, then releases port B to the core-side requester and raises `fetch_enable_o`. It sits between the riscv wrapper's memory port B and the core's port-B requester, and replaces simulation-only forcing of port B.

## Interface
Parameters:
- `ADDR_WIDTH`, 22: memory byte-address width.
- `NUM_WORDS`, 4088: number of words to preload (16352 bytes).
- `START_ADDR`, 0: byte address of the first word; must be word-aligned.
- `FUNCT_WIDTH`, 4: width of the LiM function field.
- `TIMEOUT`, 1024: maximum number of cycles to wait for `mem_rvalid_i` per word.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  start preload; level-sampled in IDLE
- `src_req_o`  in/out: out  1  request for source word `src_idx_o`
- `src_idx_o`  out  $clog2(NUM_WORDS)  source word index
- `src_valid_i`  in  1  `src_data_i` valid for the current request
- `src_data_i`  in  32  source word, little-endian byte order already packed
- `core_en_i`, `core_we_i`, `core_be_i`[4], `core_addr_i`[ADDR_WIDTH], `core_wdata_i`[32], `core_funct_i`[FUNCT_WIDTH], `core_we_funct_i`  in  core-side port-B request
- `mem_en_o`, `mem_we_o`, `mem_be_o`[4], `mem_addr_o`[ADDR_WIDTH], `mem_wdata_o`[32], `mem_funct_o`[FUNCT_WIDTH], `mem_we_funct_o`  out  memory port B
- `mem_rvalid_i`  in  1  port-B completion
- `busy_o`  out  1  preload in progress
- `done_o`  out  1  preload complete, sticky until reset
- `error_o`  out  1  timeout occurred, sticky until reset
- `fetch_enable_o`  out  1  core fetch enable
- `word_cnt_o`  out  $clog2(NUM_WORDS+1)  words committed so far

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_ACK, GAP, DRAIN, DONE, ERROR.
- IDLE: when `start_i` = 1, clear the index and go to FETCH.
- FETCH: assert `src_req_o` with `src_idx_o` = idx. When `src_valid_i` is seen, latch the data and go to ISSUE.
- ISSUE: for exactly 1 cycle drive `mem_en_o`=1, `mem_we_o`=1, `mem_be_o`=4'hF, `mem_addr_o`=START_ADDR+4·idx, `mem_wdata_o`=the latched word. Go to WAIT_ACK.
- WAIT_ACK: `mem_en_o`=0. The address, data, `we` and `be` stay held until `mem_rvalid_i`=1. Then increment `word_cnt_o` and go to GAP. If the wait counter reaches TIMEOUT, go to ERROR.
- GAP: 1 idle cycle. Then, if idx = NUM_WORDS-1, go to DRAIN; otherwise increment idx and go to FETCH.
- DRAIN: 3 idle cycles, then DONE.
- DONE: port-B outputs pass `core_*` through combinationally; `fetch_enable_o`=1. DONE is terminal until reset.
- ERROR: `error_o`=1; `fetch_enable_o` and `mem_en_o` stay at 0. ERROR is terminal until reset.
- In every state except DONE: `mem_funct_o`=0, `mem_we_funct_o`=0, and `core_*` inputs are ignored.
- `busy_o` = 1 in FETCH, ISSUE, WAIT_ACK, GAP and DRAIN.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is not flagged.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset asserted mid-operation aborts immediately: `mem_en_o` and `fetch_enable_o` drop asynchronously.
- Per-word latency: (source latency ≥1) + 1 (ISSUE) + (memory latency ≥1) + 1 (GAP).
- `mem_rvalid_i` is sampled only in WAIT_ACK. A pulse in ISSUE, or in any other state, is ignored.
- `src_valid_i` in the same cycle `src_req_o` rises is accepted (zero-wait source).
- `start_i` outside IDLE is ignored.
- `fetch_enable_o` rises in the first DONE cycle, `NUM_WORDS`·(per-word latency) + 3 cycles after `start_i`.
- Timeout: the counter restarts on entry to WAIT_ACK. ERROR is entered on cycle TIMEOUT if no `rvalid` has arrived; `rvalid` arriving on that same cycle takes priority (commit).

## Structure
- `rt_loader_pkg` holds:
  - the state enum `rt_ld_state_e`;
  - `RT_DRAIN_CYCLES`=3 and `RT_GAP_CYCLES`=1;
  - `RT_FULL_BE`=4'hF.
- Sub-module `rt_portb_mux`: a combinational 2:1 mux between loader and core port-B signals, selected by `done`, with the LiM fields forced to zero when the loader owns the port.
- FSM and counters live in the top module.

## Test plan
- NUM_WORDS=4, source latency 1, memory latency 3; pulse `start_i` -> 4 writes at addresses 0x0, 0x4, 0x8, 0xC with matching data, each with a 1-cycle `mem_en_o`; `fetch_enable_o` rises 3 cycles after the 4th GAP; `word_cnt_o`=4.
- `mem_rvalid_i` never returns with TIMEOUT=8 -> `error_o`=1 exactly 8 cycles after entering WAIT_ACK; `fetch_enable_o` stays 0; no further `mem_en_o`.
- Core drives `core_en_i`=1 with `core_funct_i`=4'h5 during preload -> `mem_funct_o`=0 and core requests are not visible. After DONE -> `mem_*` equals `core_*` in the same cycle.
- Spurious `mem_rvalid_i` in ISSUE or GAP -> `word_cnt_o` unchanged and the write sequence is unchanged.
- Assert `rst_n` low in WAIT_ACK of word 2 -> outputs 0 asynchronously. Release and restart -> loading begins from index 0 at START_ADDR.
- START_ADDR=0x3FFFFC with ADDR_WIDTH=22, NUM_WORDS=2 -> second write goes to 0x0.
